i2c_target_regfile: RTL and testbench
=====================================

// Module: i2c_target_regfile
// PURPOSE
//  Synthesisable I2C target (slave) with a parametrised register file.
//  Replaces the fixed ACK-only slave BFM as bus partner for i2c_master, and is usable in fabric.
//  Adds a register pointer, auto-increment writes/reads, repeated START, and host-side port access.
// PARAMETERS
//  SLAVE_ADDR7  7'h21  7-bit address this target responds to
//  NUM_REGS     16     register count; power of 2, 2..256; PW = $clog2(NUM_REGS)
//  SYNC_STAGES  2      synchroniser flops on scl_io/sda_io inputs (>=2)
//  HOLD_CYC     4      clk cycles from synced SCL fall to any SDA drive change (>=1)
// PORTS
//  clk         in     1   system clock
//  rst_n       in     1   asynchronous active-low reset
//  sda_io      inout  1   open-drain SDA: driven 1'b0 or 'z only
//  scl_io      inout  1   always 'z (no clock stretching); sampled only
//  host_we     in     1   host register write strobe
//  host_addr   in     PW  host register index (write and read)
//  host_wdata  in     8   host write data
//  host_rdata  out    8   regs[host_addr], combinational
//  busy        out    1   addressed transaction in progress (address ACKed until STOP)
//  wr_strobe   out    1   1-cycle pulse: I2C wrote a register
//  wr_addr     out    PW  register index for wr_strobe
//  wr_data     out    8   data for wr_strobe
// BEHAVIOUR
//  Reset: SDA released, regs all 8'h00, ptr=0, state IDLE, busy=0, wr_strobe=0, wr_addr=0, wr_data=0.
//   Reset mid-transfer releases SDA asynchronously; target then waits for the next START.
//  Input path: SYNC_STAGES flops, then edge detection on synced SCL/SDA.
//   START = SDA fall while SCL high; STOP = SDA rise while SCL high.
//   START/STOP are recognised in every state and take priority over bit handling.
//  Sampling: bits sampled on synced SCL rise, MSB first, 3-bit counter.
//   Every SDA change (ACK assert/release, read bits) happens HOLD_CYC clk after synced SCL fall.
//  FSM: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
//   IDLE -START-> ADDR; any STOP -> IDLE, busy=0; repeated START -> ADDR (ptr kept).
//   ADDR after 8 bits: addr match -> ADDR_ACK, busy=1.
//    Match + W -> PTR; match + R -> RDATA, shift reg loaded with regs[ptr].
//    Mismatch -> IGNORE: SDA never driven until next START/STOP.
//   PTR after 8 bits: ptr = byte[PW-1:0] (upper bits dropped); ACK, then WDATA.
//   WDATA after 8 bits: regs[ptr] <= byte; wr_strobe/wr_addr/wr_data pulse on the SCL rise of bit 8.
//    Then ptr++ mod NUM_REGS; ACK. Every data byte is ACKed, none NACKed.
//   RDATA: drive bits of the snapshot (bit=0 -> drive low, 1 -> release); release SDA for ACK clock.
//    At the ACK-clock SCL rise: master ACK -> ptr++ mod NUM_REGS, reload regs[ptr], stay in RDATA.
//    Master NACK -> ptr++ mod NUM_REGS, IGNORE until STOP/START.
//   Read snapshot is taken when loaded; later writes to that reg do not alter the byte in flight.
//  Host port: host_we writes regs[host_addr] on clk edge.
//   Same-cycle I2C write to the same index: I2C wins, host write dropped. Different indexes: both apply.
//  busy clears on STOP, on START of a mismatched address, and on reset.
//  Wrap: ptr at NUM_REGS-1 increments to 0, for writes and reads alike.
// TESTING (i2c_master SYS_CLK=100MHz, I2C_SPEED=100kHz, tri1 pull-ups, NUM_REGS=16)
//  Write 0x21, ptr 03, data 12 34 -> 3 data ACKs, done, regs[3]=12, regs[4]=34, 2 wr_strobe pulses.
//  Write 0x21 ptr 03; Sr read 0x21 2 bytes -> rd_data 12,34; SDA released after NACK; busy=0 after STOP.
//  Write 0x22 data DE AD -> nack_addr=1, done=1, busy never 1, no wr_strobe, regs unchanged.
//  Write 0x21 ptr 0F, data AA BB -> regs[15]=AA, regs[0]=BB; ptr byte 0x13 -> ptr=3.
//  Host writes regs[5]=5A, I2C reads ptr 05 -> 5A; host+I2C same-cycle write to reg 5 -> I2C value kept.
//  Assert rst_n low mid read byte -> SDA released <1 clk, regs=00, busy=0.
//   Next write 0x21 ptr 00 data 77 -> ACKed, regs[0]=77.
//  Bus assertion throughout: SDA changes by target never while synced SCL high.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with register pointer, auto-increment and a host-side register port.
// SDA is open-drain and every target-driven SDA change is delayed HOLD_CYC clocks past synced SCL fall.
module i2c_target_regfile #(
  parameter logic [6:0] SLAVE_ADDR7 = 7'h21,
  parameter int NUM_REGS = 16,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC = 4,
  localparam int PW = $clog2(NUM_REGS),
  localparam int HW = $clog2(HOLD_CYC + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  inout  wire           sda_io,
  inout  wire           scl_io,
  input  logic          host_we,
  input  logic [PW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          busy,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
  logic rw_q, rw_d, busy_q, busy_d, sda_oe_q, sda_oe_d;
  logic [HW-1:0] hold_q, hold_d;
  logic wr_strobe_q, wr_strobe_d;
  logic [PW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic scl_s, sda_s, start, stop, scl_rise, scl_fall, want;
  logic [7:0] byte_in;
  assign scl_io = 1'bz;
  assign sda_io = sda_oe_q ? 1'b0 : 1'bz;
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign start = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign scl_rise = scl_s & ~scl_prev_q;
  assign scl_fall = ~scl_s & scl_prev_q;
  assign byte_in = {sh_q[6:0], sda_s};
  assign ptr_inc = ptr_q + PW'(1);
  assign host_rdata = regs_q[host_addr];
  assign busy = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  // SDA level the target wants for the current SCL-low phase
  assign want = (state_q == ADDR_ACK || state_q == PTR_ACK || state_q == WDATA_ACK) ? 1'b1 :
                (state_q == RDATA) ? ~sh_q[7] : 1'b0;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    sh_d = sh_q;
    ptr_d = ptr_q;
    rw_d = rw_q;
    busy_d = busy_q;
    hold_d = hold_q;
    sda_oe_d = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    regs_d = regs_q;
    if (host_we) regs_d[host_addr] = host_wdata;
    if (scl_fall) hold_d = HW'(HOLD_CYC);
    else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
      if (hold_q == HW'(1)) sda_oe_d = want;
    end
    if (start) begin
      state_d = ADDR;
      bit_d = '0;
      hold_d = '0;
      sda_oe_d = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      busy_d = 1'b0;
      hold_d = '0;
      sda_oe_d = 1'b0;
    end else if (scl_rise) begin
      bit_d = bit_q + 3'd1;
      sh_d = byte_in;
      case (state_q)
        ADDR: if (bit_q == 3'd7) begin
          state_d = (byte_in[7:1] == SLAVE_ADDR7) ? ADDR_ACK : IGNORE;
          busy_d = byte_in[7:1] == SLAVE_ADDR7;
          rw_d = byte_in[0];
        end
        ADDR_ACK: begin
          bit_d = '0;
          state_d = rw_q ? RDATA : PTR;
          sh_d = rw_q ? regs_q[ptr_q] : sh_q;
        end
        PTR: if (bit_q == 3'd7) begin
          ptr_d = byte_in[PW-1:0];
          state_d = PTR_ACK;
        end
        PTR_ACK, WDATA_ACK: begin
          bit_d = '0;
          state_d = WDATA;
        end
        WDATA: if (bit_q == 3'd7) begin
          regs_d[ptr_q] = byte_in;
          wr_strobe_d = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = byte_in;
          ptr_d = ptr_inc;
          state_d = WDATA_ACK;
        end
        RDATA: begin
          sh_d = {sh_q[6:0], 1'b1};
          if (bit_q == 3'd7) state_d = RDATA_ACK;
        end
        RDATA_ACK: begin
          bit_d = '0;
          ptr_d = ptr_inc;
          state_d = sda_s ? IGNORE : RDATA;
          sh_d = regs_q[ptr_inc];
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q <= IDLE;
      bit_q <= '0;
      sh_q <= '0;
      ptr_q <= '0;
      rw_q <= 1'b0;
      busy_q <= 1'b0;
      hold_q <= '0;
      sda_oe_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      regs_q <= '{default: '0};
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_io};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_io};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q <= state_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      ptr_q <= ptr_d;
      rw_q <= rw_d;
      busy_q <= busy_d;
      hold_q <= hold_d;
      sda_oe_q <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      regs_q <= regs_d;
    end
  end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: bit-banged I2C master with directed transactions and immediate-assertion checks.
module tb_i2c_target_regfile;
  localparam int Q = 200;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m_scl = 1'b1, m_sda = 1'b1;
  tri1 sda, scl;
  logic host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0, host_rdata;
  logic busy, wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  int checks = 0, errors = 0;
  int strobe_n = 0, busy_cyc = 0, viol = 0;
  logic [3:0] sa [16];
  logic [7:0] sd [16];
  logic scl_p = 1'b1, sda_p = 1'b1, m_sda_p = 1'b1;
  logic ack;
  logic [7:0] rb_v;
  int s0, b0;
  assign scl = m_scl ? 1'bz : 1'b0;
  assign sda = m_sda ? 1'bz : 1'b0;
  always #5 clk = ~clk;
  i2c_target_regfile dut (
    .clk(clk), .rst_n(rst_n), .sda_io(sda), .scl_io(scl),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  always @(negedge clk) begin
    if (wr_strobe) begin
      sa[strobe_n[3:0]] <= wr_addr;
      sd[strobe_n[3:0]] <= wr_data;
      strobe_n <= strobe_n + 1;
    end
    if (busy) busy_cyc <= busy_cyc + 1;
  end
  // SDA moving while SCL stays high without the master moving it means the target changed it
  always @(posedge clk) begin
    if (scl === 1'b1 && scl_p === 1'b1 && sda !== sda_p && m_sda === m_sda_p) viol <= viol + 1;
    scl_p <= scl;
    sda_p <= sda;
    m_sda_p <= m_sda;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic reg_is(input logic [3:0] idx, input logic [7:0] exp);
    host_addr = idx;
    #1;
    chk($sformatf("reg[%0d]", idx), {24'd0, host_rdata}, {24'd0, exp});
  endtask
  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask
  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask
  task automatic wb(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; #Q;
      m_scl = 1'b1; #(2*Q);
      m_scl = 1'b0; #Q;
    end
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    a = (sda === 1'b0); #Q;
    m_scl = 1'b0; #Q;
  endtask
  task automatic rb(input logic do_ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      #Q; m_scl = 1'b1; #Q;
      b[i] = (sda === 1'b1); #Q;
      m_scl = 1'b0; #Q;
    end
    m_sda = !do_ack; #Q;
    m_scl = 1'b1; #(2*Q);
    m_scl = 1'b0; #Q;
    m_sda = 1'b1;
  endtask
  task automatic wr_ack(input string tag, input logic [7:0] b);
    wb(b, ack);
    chk(tag, {31'd0, ack}, 32'd1);
  endtask
  initial begin
    #23;
    chk("rst_sda", {31'd0, sda}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    reg_is(4'd0, 8'h00);
    #6; rst_n = 1'b1;
    #(Q - 30);
    // write ptr 3, data 12 34
    i2c_start();
    wr_ack("t1_addr_ack", 8'h42);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wr_ack("t1_ptr_ack", 8'h03);
    wr_ack("t1_d0_ack", 8'h12);
    wr_ack("t1_d1_ack", 8'h34);
    i2c_stop();
    chk("t1_busy_stop", {31'd0, busy}, 32'd0);
    chk("t1_strobes", strobe_n, 32'd2);
    chk("t1_s0", {20'd0, sa[0], sd[0]}, 32'h0312);
    chk("t1_s1", {20'd0, sa[1], sd[1]}, 32'h0434);
    reg_is(4'd3, 8'h12);
    reg_is(4'd4, 8'h34);
    // set ptr 3, repeated start, read two bytes
    i2c_start();
    wr_ack("t2_addr_ack", 8'h42);
    wr_ack("t2_ptr_ack", 8'h03);
    i2c_start();
    wr_ack("t2_raddr_ack", 8'h43);
    rb(1'b1, rb_v);
    chk("t2_rd0", {24'd0, rb_v}, 32'h12);
    rb(1'b0, rb_v);
    chk("t2_rd1", {24'd0, rb_v}, 32'h34);
    #Q;
    chk("t2_sda_rel", {31'd0, sda}, 32'd1);
    chk("t2_busy_pre", {31'd0, busy}, 32'd1);
    i2c_stop();
    chk("t2_busy_stop", {31'd0, busy}, 32'd0);
    // wrong address: everything NACKed, nothing written
    s0 = strobe_n;
    b0 = busy_cyc;
    i2c_start();
    wb(8'h44, ack);
    chk("t3_addr_nack", {31'd0, ack}, 32'd0);
    wb(8'hDE, ack);
    chk("t3_d0_nack", {31'd0, ack}, 32'd0);
    wb(8'hAD, ack);
    chk("t3_d1_nack", {31'd0, ack}, 32'd0);
    i2c_stop();
    chk("t3_busy_never", busy_cyc, b0);
    chk("t3_no_strobe", strobe_n, s0);
    reg_is(4'd3, 8'h12);
    reg_is(4'd4, 8'h34);
    // pointer wrap on write, pointer byte truncation
    i2c_start();
    wr_ack("t4_addr_ack", 8'h42);
    wr_ack("t4_ptr_ack", 8'h0F);
    wr_ack("t4_d0_ack", 8'hAA);
    wr_ack("t4_d1_ack", 8'hBB);
    i2c_stop();
    reg_is(4'd15, 8'hAA);
    reg_is(4'd0, 8'hBB);
    i2c_start();
    wr_ack("t4_addr2_ack", 8'h42);
    wr_ack("t4_ptr13_ack", 8'h13);
    i2c_stop();
    i2c_start();
    wr_ack("t4_raddr_ack", 8'h43);
    rb(1'b0, rb_v);
    chk("t4_ptr_trunc", {24'd0, rb_v}, 32'h12);
    i2c_stop();
    // pointer wrap on read
    i2c_start();
    wr_ack("t4_addr3_ack", 8'h42);
    wr_ack("t4_ptr0f_ack", 8'h0F);
    i2c_start();
    wr_ack("t4_raddr2_ack", 8'h43);
    rb(1'b1, rb_v);
    chk("t4_rd_wrap0", {24'd0, rb_v}, 32'hAA);
    rb(1'b0, rb_v);
    chk("t4_rd_wrap1", {24'd0, rb_v}, 32'hBB);
    i2c_stop();
    // host write then I2C read back
    host_addr = 4'd5; host_wdata = 8'h5A; host_we = 1'b1;
    #10; host_we = 1'b0;
    reg_is(4'd5, 8'h5A);
    i2c_start();
    wr_ack("t5_addr_ack", 8'h42);
    wr_ack("t5_ptr_ack", 8'h05);
    i2c_start();
    wr_ack("t5_raddr_ack", 8'h43);
    rb(1'b0, rb_v);
    chk("t5_rd_host", {24'd0, rb_v}, 32'h5A);
    i2c_stop();
    // same-cycle host and I2C write to reg 5: I2C value kept
    i2c_start();
    wr_ack("t5_c_addr_ack", 8'h42);
    wr_ack("t5_c_ptr_ack", 8'h05);
    host_addr = 4'd5; host_wdata = 8'hEE; host_we = 1'b1;
    fork
      wb(8'h66, ack);
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if (wr_strobe) break;
      end
    join_any
    host_we = 1'b0;
    wait fork;
    chk("t5_c_ack", {31'd0, ack}, 32'd1);
    i2c_stop();
    reg_is(4'd5, 8'h66);
    // same-cycle writes to different regs both land
    i2c_start();
    wr_ack("t5_d_addr_ack", 8'h42);
    wr_ack("t5_d_ptr_ack", 8'h05);
    host_addr = 4'd9; host_wdata = 8'h99; host_we = 1'b1;
    fork
      wb(8'h77, ack);
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if (wr_strobe) break;
      end
    join_any
    host_we = 1'b0;
    wait fork;
    i2c_stop();
    reg_is(4'd5, 8'h77);
    reg_is(4'd9, 8'h99);
    // reset in the middle of a read byte (reg 5 = 77, MSB 0 is being driven)
    i2c_start();
    wr_ack("t6_addr_ack", 8'h42);
    wr_ack("t6_ptr_ack", 8'h05);
    i2c_start();
    wr_ack("t6_raddr_ack", 8'h43);
    chk("t6_sda_driven", {31'd0, sda}, 32'd0);
    host_addr = 4'd5;
    rst_n = 1'b0;
    #3;
    chk("t6_sda_rel", {31'd0, sda}, 32'd1);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_reg5_clr", {24'd0, host_rdata}, 32'd0);
    #20; rst_n = 1'b1;
    #(Q - 23);
    i2c_stop();
    i2c_start();
    wr_ack("t6_w_addr_ack", 8'h42);
    wr_ack("t6_w_ptr_ack", 8'h00);
    wr_ack("t6_w_d_ack", 8'h77);
    i2c_stop();
    reg_is(4'd0, 8'h77);
    chk("bus_sda_hold", viol, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
